// File: rtl/cache_pkg.sv
// Shared types and defaults for the direct-mapped cache state store.
// Holds the entry layout, sweep FSM states and polarity names.
package cache_pkg;

   localparam int INDEX_W_DEF = 10;
   localparam int TAG_W_DEF   = 6;

   localparam logic READ    = 1'b0;
   localparam logic WRITE   = 1'b1;
   localparam logic ABSENT  = 1'b0;
   localparam logic PRESENT = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   typedef struct packed {
      logic                 valid;
      logic                 dirty;
      logic [TAG_W_DEF-1:0] tag;
   } entry_t;

endpackage

// File: rtl/cache_state_ram_if.sv
// Lookup/update bus between the cache controller and the state store.
// The controller is the master; the state store is the slave.
interface cache_state_ram_if
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = TAG_W_DEF
);

   logic [INDEX_W-1:0] Address;
   logic [TAG_W-1:0]   LookupTag;
   logic               Write;
   logic               ValidIn;
   logic               DirtyIn;
   logic [TAG_W-1:0]   TagIn;
   logic               SetDirty;
   logic               Flush;
   logic               ValidOut;
   logic               DirtyOut;
   logic [TAG_W-1:0]   TagOut;
   logic               Hit;
   logic               Ready;

   modport master (
      output Address, LookupTag, Write, ValidIn, DirtyIn, TagIn,
      output SetDirty, Flush,
      input  ValidOut, DirtyOut, TagOut, Hit, Ready
   );

   modport slave (
      input  Address, LookupTag, Write, ValidIn, DirtyIn, TagIn,
      input  SetDirty, Flush,
      output ValidOut, DirtyOut, TagOut, Hit, Ready
   );

endinterface

// File: rtl/clear_sweep_ctrl.sv
// Invalidate-all sweep: walks every set once after reset or flush,
// one set per cycle, and reports Ready only when idle.
module clear_sweep_ctrl
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Flush,
   output logic               clr_en,
   output logic [INDEX_W-1:0] clr_idx,
   output logic               Ready
);

   // Extra MSB keeps the terminal compare free of wrap-around.
   localparam logic [INDEX_W:0] LAST = {1'b0, {INDEX_W{1'b1}}};

   state_e           state_q, state_d;
   logic [INDEX_W:0] idx_q, idx_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (Flush) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) state_d = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end

   assign clr_en  = (state_q == CLEAR);
   assign clr_idx = idx_q[INDEX_W-1:0];
   assign Ready   = (state_q == IDLE);

endmodule

// File: rtl/cache_state_ram.sv
// Per-set valid/dirty/tag store with registered lookup and hit compare.
// Update priority is clear sweep, then write, then set-dirty.
module cache_state_ram
   import cache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = TAG_W_DEF
) (
   input logic               Clk,
   input logic               Reset,
   cache_state_ram_if.slave  bus
);

   localparam int DEPTH = 2 ** INDEX_W;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } ent_t;

   ent_t               mem_q [DEPTH];
   ent_t               cur;
   ent_t               nxt;
   logic               wr_en;
   logic               sd_en;
   logic               clr_en;
   logic [INDEX_W-1:0] clr_idx;

   logic             valid_q;
   logic             dirty_q;
   logic [TAG_W-1:0] tag_q;
   logic             hit_q;

   clear_sweep_ctrl #(
      .INDEX_W (INDEX_W)
   ) u_sweep (
      .Clk     (Clk),
      .Reset   (Reset),
      .Flush   (bus.Flush),
      .clr_en  (clr_en),
      .clr_idx (clr_idx),
      .Ready   (bus.Ready)
   );

   // nxt is the entry as it will be after this edge (write-first view).
   always_comb begin
      cur   = mem_q[bus.Address];
      wr_en = bus.Write && !clr_en;
      sd_en = bus.SetDirty && !bus.Write && !clr_en && cur.valid;
      nxt   = cur;
      if (wr_en) begin
         nxt = {bus.ValidIn, bus.DirtyIn, bus.TagIn};
      end else if (sd_en) begin
         nxt.dirty = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (clr_en) begin
            mem_q[clr_idx].valid <= ABSENT;
            mem_q[clr_idx].dirty <= 1'b0;
         end else if (wr_en || sd_en) begin
            mem_q[bus.Address] <= nxt;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_q <= 1'b0;
         dirty_q <= 1'b0;
         tag_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         valid_q <= nxt.valid && !clr_en;
         dirty_q <= nxt.dirty && !clr_en;
         tag_q   <= nxt.tag;
         hit_q   <= nxt.valid && !clr_en && (nxt.tag == bus.LookupTag);
      end
   end

   assign bus.ValidOut = valid_q;
   assign bus.DirtyOut = dirty_q;
   assign bus.TagOut   = tag_q;
   assign bus.Hit      = hit_q;

endmodule
